riscv_ctrl_pipe: RTL and testbench

Parametrised, pipelined control unit for the RV32 core. It decodes the ID-stage instruction into the standard control bundle (pc_sel, AluFun, Op1/Op2 select, WB select, RF write enable, memory r/w and size) and registers it into the EX stage. It adds load-use interlock, multi-cycle M-extension sequencing, redirect flush and external stall handling. Write enables are qualified by a valid bit, so no PC comparison is needed to suppress writes. It sits between fetch/decode and the EX datapath; branch comparison stays in EX.

---
 rtl/riscv_ctrl_pipe.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_riscv_ctrl_pipe.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ctrl_pipe.sv
// ============================================================================
//  Module   : riscv_ctrl_pipe
//  Purpose  : RV32 ID-stage decode into a registered EX control bundle with
//             load-use interlock, multi-cycle M sequencing, flush and stall.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module riscv_ctrl_pipe #(
    parameter int XLEN       = 32,
    parameter int EN_M       = 1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    output logic        id_ready,
    input  logic        ex_redirect,
    input  logic        ext_stall,
    output logic        ex_valid,
    output logic [2:0]  ex_pc_sel,
    output logic [3:0]  ex_alu_fun,
    output logic        ex_op1_sel,
    output logic [1:0]  ex_op2_sel,
    output logic [1:0]  ex_wb_sel,
    output logic        ex_rf_wen,
    output logic        ex_mem_rw,
    output logic [1:0]  ex_mem_val,
    output logic [4:0]  ex_rd,
    output logic        ex_illegal,
    output logic        md_busy,
    output logic        md_done
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] c_PS_PC4  = 3'd0;
    localparam logic [2:0] c_PS_BRCH = 3'd1;
    localparam logic [2:0] c_PS_JAL  = 3'd2;
    localparam logic [2:0] c_PS_JALR = 3'd3;
    localparam logic [2:0] c_PS_ERR  = 3'd4;

    localparam logic [3:0] c_ALU_ADD   = 4'd0;
    localparam logic [3:0] c_ALU_SUB   = 4'd1;
    localparam logic [3:0] c_ALU_SLL   = 4'd2;
    localparam logic [3:0] c_ALU_SLT   = 4'd3;
    localparam logic [3:0] c_ALU_SLTU  = 4'd4;
    localparam logic [3:0] c_ALU_XOR   = 4'd5;
    localparam logic [3:0] c_ALU_SRL   = 4'd6;
    localparam logic [3:0] c_ALU_SRA   = 4'd7;
    localparam logic [3:0] c_ALU_OR    = 4'd8;
    localparam logic [3:0] c_ALU_AND   = 4'd9;
    localparam logic [3:0] c_ALU_COPY1 = 4'd10;
    localparam logic [3:0] c_ALU_MUL   = 4'd11;
    localparam logic [3:0] c_ALU_MULH  = 4'd12;
    localparam logic [3:0] c_ALU_DIV   = 4'd13;
    localparam logic [3:0] c_ALU_REM   = 4'd14;

    localparam logic       c_OP1_IMU = 1'b1;
    localparam logic [1:0] c_OP2_IMI = 2'b00;
    localparam logic [1:0] c_OP2_IMS = 2'b01;
    localparam logic [1:0] c_OP2_RS2 = 2'b11;
    localparam logic [1:0] c_WB_ALU  = 2'b00;
    localparam logic [1:0] c_WB_PC4  = 2'b01;
    localparam logic [1:0] c_WB_MEM  = 2'b11;
    localparam logic [1:0] c_MV_B    = 2'b00;
    localparam logic [1:0] c_MV_H    = 2'b01;
    localparam logic [1:0] c_MV_W    = 2'b11;

    localparam logic [5:0] c_MUL_LOAD  = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] c_DIV_LOAD  = 6'(DIV_CYCLES - 1);
    localparam logic       c_MUL_MULTI = (MUL_CYCLES > 1);
    localparam logic       c_DIV_MULTI = (DIV_CYCLES > 1);
    localparam logic       c_M_ON      = (EN_M != 0);

    typedef struct packed {
        logic [2:0] pc_sel;
        logic [3:0] alu_fun;
        logic       op1_sel;
        logic [1:0] op2_sel;
        logic [1:0] wb_sel;
        logic       rf_wen;
        logic       mem_rw;
        logic [1:0] mem_val;
        logic [4:0] rd;
        logic       illegal;
        logic       md;
        logic       md_div;
    } bundle_t;

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [6:0] w_shf_hi;
    logic       w_use_rs1;
    logic       w_use_rs2;
    logic       w_redirect;
    logic       w_load_use;
    logic       w_md_hold;
    logic       w_load;
    bundle_t    w_dec;

    bundle_t    r_ex;
    logic       r_valid;
    logic       r_busy;
    logic [5:0] r_cnt;
    logic       r_redir_pend;

    assign w_opcode = id_instr[6:0];
    assign w_f3     = id_instr[14:12];
    assign w_f7     = id_instr[31:25];
    assign w_rs1    = id_instr[19:15];
    assign w_rs2    = id_instr[24:20];
    // RV64 shift immediates borrow bit 25 for shamt, leaving six funct bits.
    assign w_shf_hi = (XLEN == 64) ? {id_instr[31:26], 1'b0} : id_instr[31:25];

    assign w_use_rs1 = (w_opcode == c_OP_LOAD)  || (w_opcode == c_OP_ITYPE) ||
                       (w_opcode == c_OP_STORE) || (w_opcode == c_OP_RTYPE) ||
                       (w_opcode == c_OP_BRANCH)|| (w_opcode == c_OP_JALR);
    assign w_use_rs2 = (w_opcode == c_OP_RTYPE) || (w_opcode == c_OP_STORE) ||
                       (w_opcode == c_OP_BRANCH);

    always_comb begin
        w_dec        = '0;
        w_dec.pc_sel = c_PS_PC4;
        unique case (w_opcode)
            c_OP_LOAD: begin
                w_dec.op2_sel = c_OP2_IMI;
                w_dec.wb_sel  = c_WB_MEM;
                w_dec.rf_wen  = 1'b1;
                unique case (w_f3)
                    3'b000, 3'b100: w_dec.mem_val = c_MV_B;
                    3'b001, 3'b101: w_dec.mem_val = c_MV_H;
                    3'b010:         w_dec.mem_val = c_MV_W;
                    default:        w_dec.illegal = 1'b1;
                endcase
            end
            c_OP_STORE: begin
                w_dec.op2_sel = c_OP2_IMS;
                w_dec.mem_rw  = 1'b1;
                unique case (w_f3)
                    3'b000:  w_dec.mem_val = c_MV_B;
                    3'b001:  w_dec.mem_val = c_MV_H;
                    3'b010:  w_dec.mem_val = c_MV_W;
                    default: w_dec.illegal = 1'b1;
                endcase
            end
            c_OP_ITYPE: begin
                w_dec.op2_sel = c_OP2_IMI;
                w_dec.rf_wen  = 1'b1;
                unique case (w_f3)
                    3'b000: w_dec.alu_fun = c_ALU_ADD;
                    3'b010: w_dec.alu_fun = c_ALU_SLT;
                    3'b011: w_dec.alu_fun = c_ALU_SLTU;
                    3'b100: w_dec.alu_fun = c_ALU_XOR;
                    3'b110: w_dec.alu_fun = c_ALU_OR;
                    3'b111: w_dec.alu_fun = c_ALU_AND;
                    3'b001: begin
                        w_dec.alu_fun = c_ALU_SLL;
                        w_dec.illegal = (w_shf_hi != 7'b0000000);
                    end
                    default: begin
                        if (w_shf_hi == 7'b0000000)      w_dec.alu_fun = c_ALU_SRL;
                        else if (w_shf_hi == 7'b0100000) w_dec.alu_fun = c_ALU_SRA;
                        else                             w_dec.illegal = 1'b1;
                    end
                endcase
            end
            c_OP_RTYPE: begin
                w_dec.op2_sel = c_OP2_RS2;
                w_dec.rf_wen  = 1'b1;
                if (w_f7 == 7'b0000000) begin
                    unique case (w_f3)
                        3'b000: w_dec.alu_fun = c_ALU_ADD;
                        3'b001: w_dec.alu_fun = c_ALU_SLL;
                        3'b010: w_dec.alu_fun = c_ALU_SLT;
                        3'b011: w_dec.alu_fun = c_ALU_SLTU;
                        3'b100: w_dec.alu_fun = c_ALU_XOR;
                        3'b101: w_dec.alu_fun = c_ALU_SRL;
                        3'b110: w_dec.alu_fun = c_ALU_OR;
                        default: w_dec.alu_fun = c_ALU_AND;
                    endcase
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
                    w_dec.alu_fun = c_ALU_SUB;
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) begin
                    w_dec.alu_fun = c_ALU_SRA;
                end else if (w_f7 == 7'b0000001 && c_M_ON) begin
                    // Signedness variants share a code; the M unit reads funct3.
                    w_dec.md     = 1'b1;
                    w_dec.md_div = w_f3[2];
                    if (w_f3[2])              w_dec.alu_fun = w_f3[1] ? c_ALU_REM : c_ALU_DIV;
                    else if (w_f3 == 3'b000)  w_dec.alu_fun = c_ALU_MUL;
                    else                      w_dec.alu_fun = c_ALU_MULH;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            c_OP_LUI: begin
                w_dec.op1_sel = c_OP1_IMU;
                w_dec.alu_fun = c_ALU_COPY1;
                w_dec.rf_wen  = 1'b1;
            end
            c_OP_BRANCH: begin
                w_dec.pc_sel  = c_PS_BRCH;
                w_dec.illegal = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            c_OP_JAL: begin
                w_dec.pc_sel = c_PS_JAL;
                w_dec.wb_sel = c_WB_PC4;
                w_dec.rf_wen = 1'b1;
            end
            c_OP_JALR: begin
                w_dec.pc_sel  = c_PS_JALR;
                w_dec.op2_sel = c_OP2_IMI;
                w_dec.wb_sel  = c_WB_PC4;
                w_dec.rf_wen  = 1'b1;
                w_dec.illegal = (w_f3 != 3'b000);
            end
            c_OP_SYSTEM: w_dec.pc_sel = c_PS_PC4;
            default:     w_dec.illegal = 1'b1;
        endcase

        if (w_dec.illegal) begin
            w_dec         = '0;
            w_dec.illegal = 1'b1;
            w_dec.pc_sel  = c_PS_ERR;
        end
        w_dec.rd = w_dec.rf_wen ? id_instr[11:7] : 5'd0;
    end

    assign w_md_hold  = r_busy && (r_cnt != 6'd0);
    assign w_redirect = (ex_redirect || r_redir_pend) && r_valid;
    assign w_load_use = id_valid && r_valid && (r_ex.wb_sel == c_WB_MEM) && (r_ex.rd != 5'd0) &&
                        ((w_use_rs1 && (w_rs1 == r_ex.rd)) || (w_use_rs2 && (w_rs2 == r_ex.rd)));
    assign w_load     = id_valid && !w_redirect && !w_load_use;
    assign id_ready   = rst_n && !ext_stall && !w_md_hold && (w_redirect || !w_load_use);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex         <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_cnt        <= 6'd0;
            r_redir_pend <= 1'b0;
        end else if (ext_stall) begin
            if (ex_redirect && r_valid) begin
                r_redir_pend <= 1'b1;
            end
        end else if (w_md_hold) begin
            r_cnt <= r_cnt - 6'd1;
        end else begin
            r_redir_pend <= 1'b0;
            if (w_load) begin
                r_ex    <= w_dec;
                r_valid <= 1'b1;
                if (w_dec.md && w_dec.md_div) begin
                    r_busy <= c_DIV_MULTI;
                    r_cnt  <= c_DIV_LOAD;
                end else if (w_dec.md) begin
                    r_busy <= c_MUL_MULTI;
                    r_cnt  <= c_MUL_LOAD;
                end else begin
                    r_busy <= 1'b0;
                    r_cnt  <= 6'd0;
                end
            end else begin
                r_ex    <= '0;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
                r_cnt   <= 6'd0;
            end
        end
    end

    assign ex_valid   = r_valid;
    assign ex_pc_sel  = r_ex.pc_sel;
    assign ex_alu_fun = r_ex.alu_fun;
    assign ex_op1_sel = r_ex.op1_sel;
    assign ex_op2_sel = r_ex.op2_sel;
    assign ex_wb_sel  = r_ex.wb_sel;
    assign ex_rf_wen  = r_ex.rf_wen && r_valid;
    assign ex_mem_rw  = r_ex.mem_rw && r_valid;
    assign ex_mem_val = r_ex.mem_val;
    assign ex_rd      = r_ex.rd;
    assign ex_illegal = r_ex.illegal;
    assign md_busy    = r_busy;
    assign md_done    = r_valid && r_ex.md && (r_cnt == 6'd0);

endmodule

`default_nettype wire

// File: tb/tb_riscv_ctrl_pipe.sv
// ============================================================================
//  Module   : tb_riscv_ctrl_pipe
//  Purpose  : Directed bench for riscv_ctrl_pipe across three parameter sets.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_riscv_ctrl_pipe;

    localparam logic [2:0] PS_BRCH = 3'd1;
    localparam logic [2:0] PS_ERR  = 3'd4;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_MUL = 4'd11;
    localparam logic [3:0] ALU_DIV = 4'd13;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = 32'd0;
    logic        ex_redirect = 1'b0;
    logic        ext_stall = 1'b0;

    // index 0: defaults, 1: MUL_CYCLES=1, 2: EN_M=0
    logic       id_ready   [3];
    logic       ex_valid   [3];
    logic [2:0] ex_pc_sel  [3];
    logic [3:0] ex_alu_fun [3];
    logic       ex_op1_sel [3];
    logic [1:0] ex_op2_sel [3];
    logic [1:0] ex_wb_sel  [3];
    logic       ex_rf_wen  [3];
    logic       ex_mem_rw  [3];
    logic [1:0] ex_mem_val [3];
    logic [4:0] ex_rd      [3];
    logic       ex_illegal [3];
    logic       md_busy    [3];
    logic       md_done    [3];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        riscv_ctrl_pipe #(
            .XLEN       (32),
            .EN_M       ((g == 2) ? 0 : 1),
            .MUL_CYCLES ((g == 1) ? 1 : 2),
            .DIV_CYCLES (32)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .id_valid    (id_valid),
            .id_instr    (id_instr),
            .id_ready    (id_ready[g]),
            .ex_redirect (ex_redirect),
            .ext_stall   (ext_stall),
            .ex_valid    (ex_valid[g]),
            .ex_pc_sel   (ex_pc_sel[g]),
            .ex_alu_fun  (ex_alu_fun[g]),
            .ex_op1_sel  (ex_op1_sel[g]),
            .ex_op2_sel  (ex_op2_sel[g]),
            .ex_wb_sel   (ex_wb_sel[g]),
            .ex_rf_wen   (ex_rf_wen[g]),
            .ex_mem_rw   (ex_mem_rw[g]),
            .ex_mem_val  (ex_mem_val[g]),
            .ex_rd       (ex_rd[g]),
            .ex_illegal  (ex_illegal[g]),
            .md_busy     (md_busy[g]),
            .md_done     (md_done[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        id_valid    = 1'b0;
        ex_redirect = 1'b0;
        ext_stall   = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    logic [31:0] i_add, i_lw5, i_add65, i_lw0, i_add60, i_div, i_mul, i_beq, i_sw, i_auipc;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        i_add   = enc(7'b0000000, 5'd3, 5'd2, 3'b000, 5'd1,  7'h33);
        i_lw5   = enc(7'b0000000, 5'd0, 5'd1, 3'b010, 5'd5,  7'h03);
        i_add65 = enc(7'b0000000, 5'd2, 5'd5, 3'b000, 5'd6,  7'h33);
        i_lw0   = enc(7'b0000000, 5'd0, 5'd1, 3'b010, 5'd0,  7'h03);
        i_add60 = enc(7'b0000000, 5'd2, 5'd0, 3'b000, 5'd6,  7'h33);
        i_div   = enc(7'b0000001, 5'd9, 5'd8, 3'b100, 5'd7,  7'h33);
        i_mul   = enc(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd10, 7'h33);
        i_beq   = enc(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0,  7'h63);
        i_sw    = enc(7'b0000000, 5'd2, 5'd1, 3'b010, 5'd4,  7'h23);
        i_auipc = {20'h12345, 5'd3, 7'h17};

        // reset state
        do_reset();
        chk("rst_valid", ex_valid[0], 0);
        chk("rst_busy",  md_busy[0], 0);
        chk("rst_done",  md_done[0], 0);
        chk("rst_pcsel", ex_pc_sel[0], 0);

        // store decode
        id_valid = 1'b1;
        id_instr = i_sw;
        tick();
        chk("sw_memrw",  ex_mem_rw[0], 1);
        chk("sw_memval", ex_mem_val[0], 2'b11);
        chk("sw_wen",    ex_rf_wen[0], 0);
        chk("sw_op2",    ex_op2_sel[0], 2'b01);

        // asynchronous reset in the middle of a DIV
        id_instr = i_div;
        tick();
        chk("div_alu", ex_alu_fun[0], ALU_DIV);
        id_valid = 1'b0;
        repeat (4) tick();
        chk("mid_busy", md_busy[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", ex_valid[0], 0);
        chk("arst_busy",  md_busy[0], 0);
        chk("arst_wen",   ex_rf_wen[0], 0);
        chk("arst_ready", id_ready[0], 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        id_valid = 1'b1;
        id_instr = i_add;
        #1 chk("add_ready", id_ready[0], 1);
        tick();
        chk("add_valid", ex_valid[0], 1);
        chk("add_alu",   ex_alu_fun[0], ALU_ADD);
        chk("add_op2",   ex_op2_sel[0], 2'b11);
        chk("add_wen",   ex_rf_wen[0], 1);
        chk("add_rd",    ex_rd[0], 1);

        // load-use on x5
        id_instr = i_lw5;
        tick();
        chk("lw_wb",     ex_wb_sel[0], 2'b11);
        chk("lw_memval", ex_mem_val[0], 2'b11);
        chk("lw_rd",     ex_rd[0], 5);
        id_instr = i_add65;
        #1 chk("lu_ready", id_ready[0], 0);
        tick();
        chk("lu_bubble", ex_valid[0], 0);
        chk("lu_ready2", id_ready[0], 1);
        tick();
        chk("lu_valid", ex_valid[0], 1);
        chk("lu_rd",    ex_rd[0], 6);

        // load to x0 never interlocks
        id_instr = i_lw0;
        tick();
        id_instr = i_add60;
        #1 chk("lz_ready", id_ready[0], 1);
        tick();
        chk("lz_valid", ex_valid[0], 1);
        chk("lz_rd",    ex_rd[0], 6);

        // DIV occupies EX for 32 cycles
        id_instr = i_div;
        tick();
        id_instr = i_add;
        for (int k = 1; k <= 32; k++) begin
            #1;
            chk("div_busy",  md_busy[0], 1);
            chk("div_done",  md_done[0], (k == 32) ? 1 : 0);
            chk("div_ready", id_ready[0], (k < 32) ? 0 : 1);
            chk("div_rd",    ex_rd[0], 7);
            tick();
        end
        chk("div_next_busy", md_busy[0], 0);
        chk("div_next_done", md_done[0], 0);
        chk("div_next_rd",   ex_rd[0], 1);

        // single-cycle MUL versus two-cycle MUL
        do_reset();
        id_valid = 1'b1;
        id_instr = i_mul;
        tick();
        id_instr = i_add;
        #1;
        chk("m1_busy",  md_busy[1], 0);
        chk("m1_done",  md_done[1], 1);
        chk("m1_ready", id_ready[1], 1);
        chk("m1_alu",   ex_alu_fun[1], ALU_MUL);
        chk("m2_busy",  md_busy[0], 1);
        chk("m2_ready", id_ready[0], 0);
        chk("m2_done0", md_done[0], 0);
        tick();
        chk("m1_next_rd",   ex_rd[1], 1);
        chk("m1_next_done", md_done[1], 0);
        chk("m2_done1",     md_done[0], 1);
        chk("m2_rd",        ex_rd[0], 10);

        // taken branch flushes the ID instruction
        do_reset();
        id_valid = 1'b1;
        id_instr = i_beq;
        tick();
        chk("beq_pcsel", ex_pc_sel[0], PS_BRCH);
        chk("beq_wen",   ex_rf_wen[0], 0);
        chk("beq_rd",    ex_rd[0], 0);
        id_instr = i_add;
        ex_redirect = 1'b1;
        #1 chk("rd_ready", id_ready[0], 1);
        tick();
        ex_redirect = 1'b0;
        id_valid = 1'b0;
        chk("fl_valid", ex_valid[0], 0);
        chk("fl_wen",   ex_rf_wen[0], 0);
        tick();
        chk("fl_valid2", ex_valid[0], 0);

        // redirect arriving under a 3-cycle stall is applied afterwards
        id_valid = 1'b1;
        id_instr = i_beq;
        tick();
        id_instr = i_add;
        ext_stall = 1'b1;
        ex_redirect = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("st_ready", id_ready[0], 0);
            tick();
            ex_redirect = 1'b0;
            chk("st_valid", ex_valid[0], 1);
            chk("st_pcsel", ex_pc_sel[0], PS_BRCH);
        end
        ext_stall = 1'b0;
        #1 chk("st_ready4", id_ready[0], 1);
        tick();
        chk("st_flush", ex_valid[0], 0);
        chk("st_flush_wen", ex_rf_wen[0], 0);
        id_valid = 1'b0;
        tick();
        chk("st_after", ex_valid[0], 0);

        // illegal encodings
        do_reset();
        id_valid = 1'b1;
        id_instr = i_auipc;
        tick();
        chk("il_valid", ex_valid[0], 1);
        chk("il_flag",  ex_illegal[0], 1);
        chk("il_pcsel", ex_pc_sel[0], PS_ERR);
        chk("il_wen",   ex_rf_wen[0], 0);
        chk("il_mrw",   ex_mem_rw[0], 0);
        chk("il_nox",   32'($isunknown({ex_valid[0], ex_pc_sel[0], ex_alu_fun[0], ex_op1_sel[0],
                                        ex_op2_sel[0], ex_wb_sel[0], ex_rf_wen[0], ex_mem_rw[0],
                                        ex_mem_val[0], ex_rd[0], ex_illegal[0], md_busy[0],
                                        md_done[0], id_ready[0]})), 0);
        id_instr = i_mul;
        tick();
        id_valid = 1'b0;
        chk("nom_flag",  ex_illegal[2], 1);
        chk("nom_pcsel", ex_pc_sel[2], PS_ERR);
        chk("nom_wen",   ex_rf_wen[2], 0);
        chk("nom_mrw",   ex_mem_rw[2], 0);
        chk("nom_busy",  md_busy[2], 0);
        chk("nom_done",  md_done[2], 0);
        chk("m_legal",   ex_illegal[0], 0);
        chk("m_alu",     ex_alu_fun[0], ALU_MUL);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
